bnn_threshold_pack: RTL
=======================

Name: bnn_threshold_pack

Overview:
Downstream stage of the XNOR-popcount dot engine. It takes one signed dot-product accumulator per output neuron and binarizes it. Binarization is a compare against a per-neuron folded batch-norm threshold, with an optional sign flip. The resulting activation bits are packed LSB-first into WORD_W-bit words, so the next layer's dot engine can consume them directly as a_word. The output is a valid/ready word stream; a layer is framed by start and done.

Parameters:
WORD_W, 32, packed output word width; equals the dot engine's word width.
ACC_W, 32, accumulator and threshold width (signed).
N_NEURONS, 64, neurons per layer (1..65535); need not be a multiple of WORD_W.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a layer; ignored unless in IDLE
acc_valid  in  1  acc_in/thr_in/thr_flip valid
acc_ready  out  1  block accepts the current neuron
acc_in  in  ACC_W  signed dot result for the current neuron
thr_in  in  ACC_W  signed threshold for the current neuron
thr_flip  in  1  invert the binarized bit (negative BN gamma)
out_word  out  WORD_W  packed activation word
out_valid  out  1  out_word valid
out_ready  in  1  downstream accepts out_word
out_last  out  1  out_word is the final word of the layer
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse when the final word handshakes

Behaviour:
- Reset (rst=1 at a clk edge) forces the following, from any state including mid-layer:
  - state=IDLE;
  - all outputs 0;
  - bit index and neuron counter cleared;
  - the pack register is cleared;
  - any pending word is discarded.
- States:
  - IDLE: acc_ready=0. start -> RUN, with neuron counter nidx=0, bit index bidx=0 and pack register cleared.
  - RUN: acc_ready = !out_valid || out_ready. A transfer occurs when acc_valid && acc_ready.
  - DRAIN: entered when the final word loads; acc_ready=0. On the out_valid && out_ready handshake: done=1 for one cycle, then -> IDLE.
- Binarize per transfer: bit = ($signed(acc_in) >= $signed(thr_in)) XOR thr_flip.
  - The compare is signed at full ACC_W.
  - Equality yields 1 before the flip.
- Packing:
  - Neuron nidx sets bit bidx of the pack register; bidx = nidx mod WORD_W.
  - A word completes on a transfer where bidx==WORD_W-1 or nidx==N_NEURONS-1.
  - On completion, the same edge loads out_word with the packed bits including the current bit. Unfilled upper bits are 0.
  - Also on completion: out_valid=1, out_last=(nidx==N_NEURONS-1), and the pack register and bidx clear.
  - A non-completing transfer only updates the pack register, bidx and nidx.
  - Latency: the completing neuron appears in out_word one cycle after its transfer.
- Output register: out_word, out_valid and out_last are held stable while out_valid && !out_ready. out_valid clears on a handshake unless a new word loads on the same edge.
  - Back-to-back case: a handshake and a new completion on the same edge leave out_valid=1 with the new word.
- Throughput: one neuron per cycle when out_ready=1.
- Stall: acc_ready drops only while a word is pending and not being taken. Non-completing neurons are also stalled in that case; this is a deliberate simplification.
- acc_valid in IDLE or DRAIN is ignored.
- A start pulse outside IDLE is ignored.
- If start and rst are high together, rst wins.
- busy = (state!=IDLE). done and out_last are never high outside the final handshake and final word respectively.

Test Plan:
1. WORD_W=32, N_NEURONS=64, out_ready=1; neuron k gets acc=k, thr=32, flip=0 -> word0=32'h00000000, word1=32'hFFFFFFFF with out_last=1, done 1 cycle after the word1 handshake, 64 consecutive acc_ready cycles.
2. N_NEURONS=40; all bits 1 -> word0=32'hFFFFFFFF, word1=32'h000000FF with out_last=1; exactly 2 words emitted.
3. Boundary compare with ACC_W signed values:
   - acc=-5, thr=-5 -> bit 1;
   - acc=-6, thr=-5 -> 0;
   - acc=7, thr=-8 -> 1;
   - flip=1 on the same inputs -> inverted bits;
   - acc=32'h80000000, thr=0 -> 0.
4. Backpressure: hold out_ready=0 after word0 loads -> acc_ready=0 and word0 stable; neurons stall. Release -> word0 taken and streaming resumes with no lost or duplicated bits (compare against a scoreboard).
5. Random out_ready and acc_valid (50%), 3 layers back-to-back with start each time -> all words match the model; start pulsed during RUN is ignored.
6. Assert rst while in RUN at neuron 20 -> next cycle all outputs 0 and state IDLE. A new start yields a fresh layer matching the model, with no residual bits.

Source files
------------

// File: rtl/bnn_threshold_pack.sv
// rtl/bnn_threshold_pack.sv - binarize dot-product accumulators against BN thresholds and pack into words
// Output word register is loaded on the edge that completes a word; upper unfilled bits stay 0.
module bnn_threshold_pack #(
   parameter int WORD_W    = 32,
   parameter int ACC_W     = 32,
   parameter int N_NEURONS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              acc_valid,
   output logic              acc_ready,
   input  logic [ACC_W-1:0]  acc_in,
   input  logic [ACC_W-1:0]  thr_in,
   input  logic              thr_flip,
   output logic [WORD_W-1:0] out_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [15:0]       nidx;
   logic [BW-1:0]     bidx;
   logic [WORD_W-1:0] pack;
   logic [WORD_W-1:0] pack_nxt;
   logic              act_bit;
   logic              xfer;
   logic              last_neuron;
   logic              complete;
   logic              handshake;

   assign busy      = (state != IDLE);
   assign handshake = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      acc_ready = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = RUN;
         RUN:   acc_ready = !out_valid || out_ready;
         DRAIN: if (handshake) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      act_bit     = ($signed(acc_in) >= $signed(thr_in)) ^ thr_flip;
      xfer        = acc_valid && acc_ready;
      last_neuron = (nidx == 16'(N_NEURONS - 1));
      complete    = xfer && ((bidx == BW'(WORD_W - 1)) || last_neuron);
      pack_nxt    = pack | (WORD_W'(act_bit) << bidx);

      // The final neuron's transfer is the only way out of RUN.
      if (state == RUN && xfer && last_neuron) state_nxt = DRAIN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nidx      <= '0;
         bidx      <= '0;
         pack      <= '0;
         out_word  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            nidx <= '0;
            bidx <= '0;
            pack <= '0;
         end
         if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         // A completion on the same edge as a handshake overrides the clear above.
         if (xfer) begin
            nidx <= nidx + 16'd1;
            if (complete) begin
               out_word  <= pack_nxt;
               out_valid <= 1'b1;
               out_last  <= last_neuron;
               pack      <= '0;
               bidx      <= '0;
            end else begin
               pack <= pack_nxt;
               bidx <= bidx + BW'(1);
            end
         end
         if (state == DRAIN && handshake) done <= 1'b1;
      end
   end

endmodule
